// File: rtl/mips_s_pkg.sv
// Shared types and constants for the mips_s multicycle core: FSM states, ALU ops,
// opcode/funct encodings and the instruction-to-control decode helper.
package mips_s_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0040_0000;
  localparam logic [31:0] DEF_SP_INIT  = 32'h7FFF_EFFC;
  localparam logic [31:0] DEF_GP_INIT  = 32'h1000_8000;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WBK, LOAD, STORE} state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;

  typedef enum logic [1:0] {DEST_RT, DEST_RD, DEST_RA} dest_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW     = 6'h23, OP_LBU   = 6'h24;
  localparam logic [5:0] OP_SB    = 6'h28, OP_SW     = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR   = 6'h08, F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B;

  typedef struct packed {
    alu_op_t alu_op;
    dest_t   dest;
    logic    use_imm;
    logic    zero_ext;
    logic    const_shift;
    logic    is_load;
    logic    is_store;
    logic    is_byte;
    logic    is_branch;
    logic    is_jump;
    logic    is_jreg;
    logic    link;
    logic    writes;
  } ctrl_t;

  // Anything not matched leaves every flag clear, which EXEC treats as a NOP.
  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct,
                                   input logic [4:0] rt);
    ctrl_t c;
    c        = '0;
    c.alu_op = ALU_ADD;
    c.dest   = DEST_RT;
    case (op)
      OP_RTYPE: begin
        c.dest   = DEST_RD;
        c.writes = 1'b1;
        case (funct)
          F_SLL:         begin c.alu_op = ALU_SLL; c.const_shift = 1'b1; end
          F_SRL:         begin c.alu_op = ALU_SRL; c.const_shift = 1'b1; end
          F_SRA:         begin c.alu_op = ALU_SRA; c.const_shift = 1'b1; end
          F_SLLV:        c.alu_op = ALU_SLL;
          F_SRLV:        c.alu_op = ALU_SRL;
          F_SRAV:        c.alu_op = ALU_SRA;
          F_JR:          begin c.is_jreg = 1'b1; c.writes = 1'b0; end
          F_JALR:        begin c.is_jreg = 1'b1; c.link = 1'b1; end
          F_ADD, F_ADDU: c.alu_op = ALU_ADD;
          F_SUB, F_SUBU: c.alu_op = ALU_SUB;
          F_AND:         c.alu_op = ALU_AND;
          F_OR:          c.alu_op = ALU_OR;
          F_XOR:         c.alu_op = ALU_XOR;
          F_NOR:         c.alu_op = ALU_NOR;
          F_SLT:         c.alu_op = ALU_SLT;
          F_SLTU:        c.alu_op = ALU_SLTU;
          default:       c.writes = 1'b0;
        endcase
      end
      OP_REGIMM: if (rt == 5'd0 || rt == 5'd1) begin
        c.is_branch = 1'b1;
        c.alu_op    = ALU_SUB;
      end
      OP_J:   c.is_jump = 1'b1;
      OP_JAL: begin c.is_jump = 1'b1; c.link = 1'b1; c.writes = 1'b1; c.dest = DEST_RA; end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin c.is_branch = 1'b1; c.alu_op = ALU_SUB; end
      OP_ADDI, OP_ADDIU: begin c.use_imm = 1'b1; c.writes = 1'b1; end
      OP_SLTI:  begin c.alu_op = ALU_SLT;  c.use_imm = 1'b1; c.writes = 1'b1; end
      OP_SLTIU: begin c.alu_op = ALU_SLTU; c.use_imm = 1'b1; c.writes = 1'b1; end
      OP_ANDI:  begin c.alu_op = ALU_AND; c.use_imm = 1'b1; c.zero_ext = 1'b1; c.writes = 1'b1; end
      OP_ORI:   begin c.alu_op = ALU_OR;  c.use_imm = 1'b1; c.zero_ext = 1'b1; c.writes = 1'b1; end
      OP_XORI:  begin c.alu_op = ALU_XOR; c.use_imm = 1'b1; c.zero_ext = 1'b1; c.writes = 1'b1; end
      OP_LUI:   begin c.alu_op = ALU_LUI; c.use_imm = 1'b1; c.writes = 1'b1; end
      OP_LW:    begin c.use_imm = 1'b1; c.is_load = 1'b1; c.writes = 1'b1; end
      OP_LBU:   begin c.use_imm = 1'b1; c.is_load = 1'b1; c.is_byte = 1'b1; c.writes = 1'b1; end
      OP_SW:    begin c.use_imm = 1'b1; c.is_store = 1'b1; end
      OP_SB:    begin c.use_imm = 1'b1; c.is_store = 1'b1; c.is_byte = 1'b1; end
      default:  c.alu_op = ALU_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_s_alu.sv
// Combinational ALU for mips_s. Shifts move operand b by i_a[4:0]; LUI places b[15:0] in the top half.
module mips_s_alu
  import mips_s_pkg::*;
(
  input  alu_op_t     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result,
  output logic        o_zero
);

  always_comb begin
    // NOTE: a default assignment first means no path leaves o_result unassigned, so no latch.
    o_result = '0;
    case (i_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_NOR:  o_result = ~(i_a | i_b);
      ALU_SLT:  o_result = {31'd0, $signed(i_a) < $signed(i_b)};
      ALU_SLTU: o_result = {31'd0, i_a < i_b};
      ALU_SLL:  o_result = i_b << i_a[4:0];
      ALU_SRL:  o_result = i_b >> i_a[4:0];
      ALU_SRA:  o_result = $unsigned($signed(i_b) >>> i_a[4:0]);
      ALU_LUI:  o_result = {i_b[15:0], 16'd0};
      default:  o_result = '0;
    endcase
  end

  assign o_zero = (o_result == 32'd0);

endmodule

// File: rtl/mips_s.sv
// Multicycle MIPS integer core: FETCH/DECODE/EXEC then WBK, LOAD or STORE as needed.
// 'hold' freezes all state, so every output (all decoded from registers) stays put.
module mips_s
  import mips_s_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] SP_INIT  = DEF_SP_INIT,
  parameter logic [31:0] GP_INIT  = DEF_GP_INIT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hold,
  input  logic [31:0] instruction,
  output logic [31:0] i_address,
  output logic        ce,
  output logic        rw,
  output logic        bw,
  output logic [31:0] d_address,
  inout  wire  [31:0] data
);

  state_t      r_state;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_imm, r_alu, r_mdr;
  logic [31:0] r_rf [32];

  ctrl_t       w_ctrl;
  logic [4:0]  w_rs, w_rt, w_rd, w_dest;
  logic [31:0] w_rs_val, w_rt_val, w_alu_a, w_alu_b, w_alu_result;
  logic [31:0] w_store_data, w_wb_data, w_jump_target;
  logic [7:0]  w_byte;
  logic        w_zero, w_taken;

  assign w_rs   = r_ir[25:21];
  assign w_rt   = r_ir[20:16];
  assign w_rd   = r_ir[15:11];
  assign w_ctrl = decode(r_ir[31:26], r_ir[5:0], w_rt);

  assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];

  assign w_alu_a = w_ctrl.const_shift ? {27'd0, r_ir[10:6]} : r_a;
  assign w_alu_b = w_ctrl.use_imm ? r_imm : r_b;

  mips_s_alu u_alu (
    .i_op     (w_ctrl.alu_op),
    .i_a      (w_alu_a),
    .i_b      (w_alu_b),
    .o_result (w_alu_result),
    .o_zero   (w_zero)
  );

  // Single-operand branches have rt = $0, so w_zero means rs == 0 for them.
  always_comb begin
    w_taken = 1'b0;
    case (r_ir[31:26])
      OP_BEQ:    w_taken = w_zero;
      OP_BNE:    w_taken = !w_zero;
      OP_BLEZ:   w_taken = r_a[31] || w_zero;
      OP_BGTZ:   w_taken = !r_a[31] && !w_zero;
      OP_REGIMM: w_taken = r_ir[16] ? !r_a[31] : r_a[31];
      default:   w_taken = 1'b0;
    endcase
  end

  assign w_jump_target = {r_pc[31:28], r_ir[25:0], 2'b00};
  assign w_dest = (w_ctrl.dest == DEST_RD) ? w_rd :
                  (w_ctrl.dest == DEST_RA) ? 5'd31 : w_rt;
  assign w_wb_data = w_ctrl.is_load ? r_mdr : r_alu;
  assign w_byte = data[8*r_alu[1:0] +: 8];
  assign w_store_data = w_ctrl.is_byte ? {4{r_b[7:0]}} : r_b;

  assign i_address = r_pc;
  assign d_address = r_alu;
  assign ce        = (r_state == LOAD) || (r_state == STORE);
  assign rw        = (r_state != STORE);
  assign bw        = !(ce && w_ctrl.is_byte);
  assign data      = (ce && !rw) ? w_store_data : 32'bz;

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= '0;
      r_alu   <= '0;
      r_mdr   <= '0;
      // NOTE: the register file is reset explicitly because $28/$29 must start preloaded.
      for (int i = 0; i < 32; i++)
        r_rf[i] <= (i == 28) ? GP_INIT : (i == 29) ? SP_INIT : 32'd0;
    end else if (!hold) begin
      case (r_state)
        FETCH: begin
          r_ir    <= instruction;
          r_pc    <= r_pc + 32'd4;
          r_state <= DECODE;
        end
        DECODE: begin
          r_a     <= w_rs_val;
          r_b     <= w_rt_val;
          r_imm   <= w_ctrl.zero_ext ? {16'd0, r_ir[15:0]} : {{16{r_ir[15]}}, r_ir[15:0]};
          r_state <= EXEC;
        end
        EXEC: begin
          r_alu   <= w_alu_result;
          r_state <= FETCH;
          if (w_ctrl.is_branch) begin
            if (w_taken) r_pc <= r_pc + {r_imm[29:0], 2'b00};
          end else if (w_ctrl.is_jump || w_ctrl.is_jreg) begin
            r_pc <= w_ctrl.is_jump ? w_jump_target : r_a;
            if (w_ctrl.link) begin
              r_alu   <= r_pc;
              r_state <= WBK;
            end
          end else if (w_ctrl.is_load) begin
            r_state <= LOAD;
          end else if (w_ctrl.is_store) begin
            r_state <= STORE;
          end else if (w_ctrl.writes) begin
            r_state <= WBK;
          end
        end
        LOAD: begin
          r_mdr   <= w_ctrl.is_byte ? {24'd0, w_byte} : data;
          r_state <= WBK;
        end
        STORE: r_state <= FETCH;
        WBK: begin
          if (w_dest != 5'd0) r_rf[w_dest] <= w_wb_data;
          r_state <= FETCH;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_s.sv
// Directed program for mips_s with a small instruction ROM and byte-lane data memory.
// Expected values are hand-computed from the instruction encodings below.
module tb_mips_s;
  import mips_s_pkg::*;

  logic        clock, reset, hold;
  logic [31:0] instruction, i_address, d_address;
  logic        ce, rw, bw;
  wire  [31:0] data;

  logic [31:0] imem [32];
  logic [31:0] dmem [16];

  int n_cmp = 0;
  int n_bad = 0;

  logic        st_ce, st_rw, st_bw;
  logic [31:0] st_addr, st_data;

  mips_s dut (
    .clock       (clock),
    .reset       (reset),
    .hold        (hold),
    .instruction (instruction),
    .i_address   (i_address),
    .ce          (ce),
    .rw          (rw),
    .bw          (bw),
    .d_address   (d_address),
    .data        (data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign instruction = imem[i_address[6:2]];
  assign data = (ce && rw) ? dmem[d_address[5:2]] : 32'bz;

  always @(posedge clock) begin
    if (!reset && !hold && ce && !rw) begin
      if (bw) dmem[d_address[5:2]] <= data;
      else    dmem[d_address[5:2]][8*d_address[1:0] +: 8] <= data[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Called at a negedge with the core in FETCH; runs one instruction and checks PC and CPI.
  task automatic run_instr(input string tag, input logic [31:0] exp_pc,
                           input int exp_cyc, input int n_hold);
    int          cyc;
    int          held;
    logic [31:0] snap_addr, snap_data;
    logic [1:0]  snap_ctl;
    cyc = 0; held = 0;
    snap_addr = '0; snap_data = '0; snap_ctl = '0;
    st_ce = 1'b0; st_rw = 1'b1; st_bw = 1'b1; st_addr = '0; st_data = '0;
    check({tag, "_pc"}, i_address, exp_pc);
    do begin
      if (dut.r_state == STORE) begin
        st_ce = ce; st_rw = rw; st_bw = bw; st_addr = d_address; st_data = data;
      end
      if (dut.r_state == LOAD && held < n_hold) begin
        if (held == 0) begin
          snap_addr = d_address; snap_data = data; snap_ctl = {ce, rw};
        end
        hold = 1'b1;
        held++;
      end else begin
        hold = 1'b0;
      end
      @(posedge clock);
      @(negedge clock);
      cyc++;
      if (hold) begin
        check({tag, "_hold_ctl"},  {30'd0, ce, rw}, {30'd0, snap_ctl});
        check({tag, "_hold_addr"}, d_address, snap_addr);
        check({tag, "_hold_data"}, data, snap_data);
      end
    end while (dut.r_state != FETCH && cyc < 20);
    hold = 1'b0;
    check({tag, "_cpi"}, cyc, exp_cyc);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) imem[i] = 32'hFC00_0000;
    for (int i = 0; i < 16; i++) dmem[i] = 32'd0;
    dmem[0] = 32'hCAFE_BEBA;
    imem[5'h00] = 32'hFC00_0000; // unsupported opcode: NOP
    imem[5'h01] = 32'h2408_FFFF; // addiu $8,$0,-1
    imem[5'h02] = 32'h0108_4821; // addu  $9,$8,$8
    imem[5'h03] = 32'h3C0A_1001; // lui   $10,0x1001
    imem[5'h04] = 32'h1000_0002; // beq   $0,$0,+2
    imem[5'h05] = 32'h2408_0005; // addiu $8,$0,5 (skipped)
    imem[5'h06] = 32'h2408_0005; // addiu $8,$0,5 (skipped)
    imem[5'h07] = 32'h1400_0002; // bne   $0,$0,+2
    imem[5'h08] = 32'hAD49_0004; // sw    $9,4($10)
    imem[5'h09] = 32'h8D4B_0004; // lw    $11,4($10)
    imem[5'h0A] = 32'h3C0C_1234; // lui   $12,0x1234
    imem[5'h0B] = 32'h358C_5678; // ori   $12,$12,0x5678
    imem[5'h0C] = 32'hA14C_0002; // sb    $12,2($10)
    imem[5'h0D] = 32'h914D_0001; // lbu   $13,1($10)
    imem[5'h0E] = 32'h914E_0002; // lbu   $14,2($10)
    imem[5'h0F] = 32'h0100_782A; // slt   $15,$8,$0
    imem[5'h10] = 32'h0100_802B; // sltu  $16,$8,$0
    imem[5'h11] = 32'h0009_8903; // sra   $17,$9,4
    imem[5'h12] = 32'h0009_9102; // srl   $18,$9,4
    imem[5'h13] = 32'h0C10_0018; // jal   0x00400060
    imem[5'h14] = 32'h2413_0007; // addiu $19,$0,7
    imem[5'h15] = 32'h0810_0015; // j     0x00400054
    imem[5'h18] = 32'h3914_00FF; // xori  $20,$8,0xFF
    imem[5'h19] = 32'h03E0_0008; // jr    $31

    reset = 1'b1;
    hold  = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_pc",  i_address, 32'h0040_0000);
    check("rst_ctl", {29'd0, ce, rw, bw}, 32'd3);
    check("rst_dad", d_address, 32'd0);
    check("rst_sp",  dut.r_rf[29], 32'h7FFF_EFFC);
    check("rst_gp",  dut.r_rf[28], 32'h1000_8000);
    reset = 1'b0;

    run_instr("nop",   32'h0040_0000, 3, 0);
    run_instr("addiu", 32'h0040_0004, 4, 0);
    check("r8", dut.r_rf[8], 32'hFFFF_FFFF);
    run_instr("addu",  32'h0040_0008, 4, 0);
    check("r9", dut.r_rf[9], 32'hFFFF_FFFE);
    run_instr("lui",   32'h0040_000C, 4, 0);
    check("r10", dut.r_rf[10], 32'h1001_0000);
    run_instr("beq",   32'h0040_0010, 3, 0);
    run_instr("bne",   32'h0040_001C, 3, 0);
    run_instr("sw",    32'h0040_0020, 4, 0);
    check("sw_ctl",  {29'd0, st_ce, st_rw, st_bw}, 32'd5);
    check("sw_addr", st_addr, 32'h1001_0004);
    check("sw_data", st_data, 32'hFFFF_FFFE);
    check("sw_mem",  dmem[1], 32'hFFFF_FFFE);
    run_instr("lw",    32'h0040_0024, 8, 3);
    check("r11", dut.r_rf[11], 32'hFFFF_FFFE);
    run_instr("lui2",  32'h0040_0028, 4, 0);
    run_instr("ori",   32'h0040_002C, 4, 0);
    check("r12", dut.r_rf[12], 32'h1234_5678);
    run_instr("sb",    32'h0040_0030, 4, 0);
    check("sb_ctl",  {29'd0, st_ce, st_rw, st_bw}, 32'd4);
    check("sb_addr", st_addr, 32'h1001_0002);
    check("sb_data", st_data, 32'h7878_7878);
    check("sb_mem",  dmem[0], 32'hCA78_BEBA);
    run_instr("lbu1",  32'h0040_0034, 5, 0);
    check("r13", dut.r_rf[13], 32'h0000_00BE);
    run_instr("lbu2",  32'h0040_0038, 5, 0);
    check("r14", dut.r_rf[14], 32'h0000_0078);
    run_instr("slt",   32'h0040_003C, 4, 0);
    check("r15", dut.r_rf[15], 32'd1);
    run_instr("sltu",  32'h0040_0040, 4, 0);
    check("r16", dut.r_rf[16], 32'd0);
    run_instr("sra",   32'h0040_0044, 4, 0);
    check("r17", dut.r_rf[17], 32'hFFFF_FFFF);
    run_instr("srl",   32'h0040_0048, 4, 0);
    check("r18", dut.r_rf[18], 32'h0FFF_FFFF);
    run_instr("jal",   32'h0040_004C, 4, 0);
    check("r31", dut.r_rf[31], 32'h0040_0050);
    run_instr("xori",  32'h0040_0060, 4, 0);
    check("r20", dut.r_rf[20], 32'hFFFF_FF00);
    run_instr("jr",    32'h0040_0064, 3, 0);
    run_instr("ret",   32'h0040_0050, 4, 0);
    check("r19", dut.r_rf[19], 32'd7);
    run_instr("j",     32'h0040_0054, 3, 0);
    check("j_pc", i_address, 32'h0040_0054);
    check("r8_kept", dut.r_rf[8], 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
